// File: rtl/dns_sequencer_if.sv
// Control/handshake bundle between the DNS phase sequencer and its neighbours
// (host start/done, operand memory fetch, PE-grid strobes, result stream).
interface dns_sequencer_if #(
    parameter int N = 4
);
    localparam int LOGN = $clog2(N);
    localparam int IW   = 2 * LOGN;

    logic            start;
    logic            busy;
    logic            done;
    logic            op_rd;
    logic            op_sel_b;
    logic [IW-1:0]   op_addr;
    logic            pe_copya;
    logic            pe_copyb;
    logic            pe_bcast;
    logic            pe_mul;
    logic            pe_sum;
    logic [LOGN-1:0] sum_step;
    logic            res_valid;
    logic [IW-1:0]   res_addr;
    logic            res_ready;

    modport master (
        input  start, res_ready,
        output busy, done, op_rd, op_sel_b, op_addr,
               pe_copya, pe_copyb, pe_bcast, pe_mul, pe_sum, sum_step,
               res_valid, res_addr
    );

    modport slave (
        output start, res_ready,
        input  busy, done, op_rd, op_sel_b, op_addr,
               pe_copya, pe_copyb, pe_bcast, pe_mul, pe_sum, sum_step,
               res_valid, res_addr
    );
endinterface

// File: rtl/dns_sequencer.sv
// Phase controller for the N x N x N DNS grid: load A, load B, broadcast,
// multiply, log2(N) z-reduction steps, then a valid/ready result drain.
module dns_sequencer #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    dns_sequencer_if.master  bus
);
    localparam int LOGN = $clog2(N);
    localparam int IW   = 2 * LOGN;
    localparam logic [IW-1:0]   IDX_LAST  = IW'(N * N - 1);
    localparam logic [LOGN-1:0] STEP_LAST = LOGN'(LOGN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_BCAST, S_MUL, S_REDUCE, S_DRAIN, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LOGN-1:0] step_q, step_d;

    logic            busy_q, done_q, op_rd_q, op_sel_b_q;
    logic [IW-1:0]   op_addr_q, res_addr_q;
    logic            copya_q, copyb_q, bcast_q, mul_q, sum_q, res_valid_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = '0;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (bus.start) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_LOAD_B;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_LOAD_B: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_BCAST;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_BCAST:  state_d = S_MUL;
            S_MUL:    state_d = S_REDUCE;
            S_REDUCE: begin
                if (step_q == STEP_LAST) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // idx only advances on an accepted beat, so the presented element holds under backpressure
                if (bus.res_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            step_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            op_rd_q     <= 1'b0;
            op_sel_b_q  <= 1'b0;
            op_addr_q   <= '0;
            copya_q     <= 1'b0;
            copyb_q     <= 1'b0;
            bcast_q     <= 1'b0;
            mul_q       <= 1'b0;
            sum_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            op_rd_q     <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
            op_sel_b_q  <= (state_d == S_LOAD_B);
            op_addr_q   <= ((state_d == S_LOAD_A) || (state_d == S_LOAD_B)) ? idx_d : '0;
            copya_q     <= (state_d == S_LOAD_A);
            copyb_q     <= (state_d == S_LOAD_B);
            bcast_q     <= (state_d == S_BCAST);
            mul_q       <= (state_d == S_MUL);
            sum_q       <= (state_d == S_REDUCE);
            res_valid_q <= (state_d == S_DRAIN);
            res_addr_q  <= (state_d == S_DRAIN) ? idx_d : '0;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.op_rd     = op_rd_q;
    assign bus.op_sel_b  = op_sel_b_q;
    assign bus.op_addr   = op_addr_q;
    assign bus.pe_copya  = copya_q;
    assign bus.pe_copyb  = copyb_q;
    assign bus.pe_bcast  = bcast_q;
    assign bus.pe_mul    = mul_q;
    assign bus.pe_sum    = sum_q;
    assign bus.sum_step  = step_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_addr  = res_addr_q;
endmodule

// File: tb/tb_dns_sequencer.sv
// Directed bench for dns_sequencer: N=4 and N=2 instances, cycle-by-cycle
// output vectors checked against a hand-written job timeline.
module tb_dns_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dns_sequencer_if #(.N(4)) b4 ();
    dns_sequencer_if #(.N(2)) b2 ();

    dns_sequencer #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    dns_sequencer #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    function automatic logic [31:0] pack(bit busy, bit done, bit rd, bit selb, int addr,
                                         bit ca, bit cb, bit bc, bit mu, bit su, int step,
                                         bit rv, int raddr);
        return {2'b00, busy, done, rd, selb, 8'(addr), ca, cb, bc, mu, su,
                4'(step), rv, 8'(raddr)};
    endfunction

    // Expected outputs for cycle c of an unstalled job whose start was sampled in cycle 0
    function automatic logic [31:0] exp_vec(int c, int n);
        int n2;
        int logn;
        n2   = n * n;
        logn = $clog2(n);
        if (c < 1)                     return '0;
        if (c <= n2)                   return pack(1,0,1,0,c-1,      1,0,0,0,0,0,0,0);
        if (c <= 2*n2)                 return pack(1,0,1,1,c-n2-1,   0,1,0,0,0,0,0,0);
        if (c == 2*n2+1)               return pack(1,0,0,0,0,        0,0,1,0,0,0,0,0);
        if (c == 2*n2+2)               return pack(1,0,0,0,0,        0,0,0,1,0,0,0,0);
        if (c <= 2*n2+2+logn)          return pack(1,0,0,0,0,        0,0,0,0,1,c-2*n2-3,0,0);
        if (c <= 3*n2+2+logn)          return pack(1,0,0,0,0,        0,0,0,0,0,0,1,c-2*n2-3-logn);
        if (c == 3*n2+3+logn)          return pack(1,1,0,0,0,        0,0,0,0,0,0,0,0);
        return '0;
    endfunction

    function automatic logic [31:0] get_vec(int n);
        if (n == 2)
            return pack(b2.busy, b2.done, b2.op_rd, b2.op_sel_b, int'(b2.op_addr),
                        b2.pe_copya, b2.pe_copyb, b2.pe_bcast, b2.pe_mul, b2.pe_sum,
                        int'(b2.sum_step), b2.res_valid, int'(b2.res_addr));
        return pack(b4.busy, b4.done, b4.op_rd, b4.op_sel_b, int'(b4.op_addr),
                    b4.pe_copya, b4.pe_copyb, b4.pe_bcast, b4.pe_mul, b4.pe_sum,
                    int'(b4.sum_step), b4.res_valid, int'(b4.res_addr));
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_start(input int n, input bit v);
        if (n == 2) b2.start = v;
        else        b4.start = v;
    endtask

    // Runs from cycle 0 (start asserted now) through last_c, checking every cycle.
    // Optional stall drops res_ready for stall_len cycles from stall_c; start_until keeps
    // start high up to that cycle; restart maps cycles past one job period onto a second job.
    task automatic run_job(input string name, input int n, input int last_c, input int stall_c,
                           input int stall_len, input int start_until, input bit restart);
        int ce;
        int period;
        period = 3*n*n + $clog2(n) + 4;
        set_start(n, 1'b1);
        b4.res_ready = 1'b1;
        b2.res_ready = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            step_cycle();
            ce = c;
            if (stall_len > 0 && c >= stall_c)
                ce = (c < stall_c + stall_len) ? stall_c : c - stall_len;
            if (restart && ce > period)
                ce = ce - period;
            check_vec($sformatf("%s_c%0d", name, c), get_vec(n), exp_vec(ce, n));
            set_start(n, c < start_until);
            b4.res_ready = !(stall_len > 0 && c >= stall_c && c < stall_c + stall_len);
        end
        set_start(n, 1'b0);
        b4.res_ready = 1'b1;
    endtask

    initial begin
        b4.start = 1'b0; b4.res_ready = 1'b1;
        b2.start = 1'b0; b2.res_ready = 1'b1;

        // Reset with random start: everything stays 0
        for (int k = 0; k < 2; k++) begin
            b4.start = 1'($urandom);
            b2.start = 1'($urandom);
            step_cycle();
            check_vec($sformatf("rst_n4_%0d", k), get_vec(4), '0);
            check_vec($sformatf("rst_n2_%0d", k), get_vec(2), '0);
        end
        b4.start = 1'b0;
        b2.start = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_cycle();
            check_vec($sformatf("idle_n4_%0d", k), get_vec(4), '0);
            check_vec($sformatf("idle_n2_%0d", k), get_vec(2), '0);
        end

        // Full N=4 job: done at 53, idle at 54
        run_job("job4", 4, 56, 0, 0, 1, 1'b0);

        // Backpressure: hold for 5 cycles at res_addr=7 (cycles 44..48), done at 58
        run_job("bp4", 4, 60, 44, 5, 1, 1'b0);

        // start held high: second job begins LOAD_A at cycle 55 and runs to completion
        run_job("hold4", 4, 60, 0, 0, 61, 1'b1);
        for (int c = 61; c <= 112; c++) begin
            step_cycle();
            check_vec($sformatf("hold4_c%0d", c), get_vec(4), exp_vec(c - 54, 4));
        end

        // Reset mid LOAD_B at op_addr=5 (cycle 22): idle next cycle, no done, clean restart
        b4.start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step_cycle();
            check_vec($sformatf("abort4_c%0d", c), get_vec(4), exp_vec(c, 4));
            b4.start = 1'b0;
        end
        rst = 1'b1;
        step_cycle();
        check_vec("abort4_rst", get_vec(4), '0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_cycle();
            check_vec($sformatf("abort4_idle%0d", k), get_vec(4), '0);
        end
        run_job("restart4", 4, 55, 0, 0, 1, 1'b0);

        // N=2 instance: done at cycle 16
        run_job("job2", 2, 18, 0, 0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
